dmem_hs: RTL and testbench



---
 rtl/dmem_pkg.sv | 15 +
 rtl/dmem_array.sv | 49 ++++
 rtl/dmem_hs.sv | 171 +++++++++++++++++
 tb/tb_dmem_hs.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the handshaked data memory (dmem_hs).
package dmem_pkg;

    localparam int LAT_W       = 3;
    localparam int BYTE_W      = 8;
    localparam int MAX_LATENCY = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        RESP  = 2'd2,
        CLEAR = 2'd3
    } state_e;

endpackage

// File: rtl/dmem_array.sv
// DEPTH x DATA_W storage: synchronous byte-lane write, registered read port with
// an explicit force-to-zero for out-of-range reads.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    parameter int IDX_W  = 6
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we_i,
    input  logic                     re_i,
    input  logic                     zero_i,
    input  logic [IDX_W-1:0]         idx_i,
    input  logic [DATA_W-1:0]        wdata_i,
    input  logic [DATA_W/BYTE_W-1:0] be_i,
    output logic [DATA_W-1:0]        rdata_o
);

    localparam int NB = DATA_W / BYTE_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int b = 0; b < NB; b++) begin
                if (be_i[b]) begin
                    mem_q[idx_i][b*BYTE_W +: BYTE_W] <= wdata_i[b*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    // A write leaves the last read result in place.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (zero_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[idx_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_hs.sv
// Handshaked data memory: LATENCY wait states, byte-lane writes, range error, one-cycle response.
// Define DMEM_INIT_EN to zero the array with a CLEAR sweep after every reset.
module dmem_hs
    import dmem_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 64,
    parameter int ADDR_W  = 32,
    parameter int LATENCY = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        addr,
    input  logic [DATA_W-1:0]        write_data,
    input  logic [DATA_W/BYTE_W-1:0] byte_en,
    output logic                     ready,
    output logic                     rvalid,
    output logic [DATA_W-1:0]        read_data,
    output logic                     err
);

    localparam int NB    = DATA_W / BYTE_W;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int WIDX  = ADDR_W - 2;
    localparam logic [WIDX:0] DEPTH_X = (WIDX+1)'(DEPTH);
`ifdef DMEM_INIT_EN
    localparam state_e RESET_ST = CLEAR;
`else
    localparam state_e RESET_ST = IDLE;
`endif

    state_e            state_q, state_d;
    logic [LAT_W-1:0]  cnt_q, cnt_d;
    logic              we_q, oor_q;
    logic [WIDX-1:0]   idx_q;
    logic [DATA_W-1:0] wdata_q;
    logic [NB-1:0]     be_q;

    logic              accept, commit, clr_done;
    logic              c_we, c_oor;
    logic [WIDX-1:0]   c_idx;
    logic [DATA_W-1:0] c_wdata;
    logic [NB-1:0]     c_be;
    logic              arr_we, arr_re, arr_zero;
    logic [IDX_W-1:0]  arr_idx;
    logic [DATA_W-1:0] arr_wdata;
    logic [NB-1:0]     arr_be;
    logic              unused_addr_lsb;

    assign unused_addr_lsb = ^addr[1:0];
    assign ready  = (state_q == IDLE) || (state_q == RESP);
    assign rvalid = (state_q == RESP);
    assign err    = rvalid && oor_q;
    assign accept = req && ready;

    // With no wait states the request commits on its own accept edge, straight from the ports.
    always_comb begin
        c_we    = we_q;
        c_idx   = idx_q;
        c_wdata = wdata_q;
        c_be    = be_q;
        if (LATENCY == 0) begin
            c_we    = we;
            c_idx   = addr[ADDR_W-1:2];
            c_wdata = write_data;
            c_be    = byte_en;
        end
        c_oor = {1'b0, c_idx} >= DEPTH_X;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE, RESP: begin
                state_d = IDLE;
                if (accept) begin
                    if (LATENCY == 0) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = LAT_W'(LATENCY - 1);
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) state_d = RESP;
                else             cnt_d   = cnt_q - LAT_W'(1);
            end
            CLEAR: begin
                if (clr_done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign commit = reset && (state_d == RESP);

`ifdef DMEM_INIT_EN
    logic [IDX_W-1:0] clr_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                 clr_q <= '0;
        else if (state_q == CLEAR)  clr_q <= clr_q + IDX_W'(1);
    end

    assign clr_done = (clr_q == IDX_W'(DEPTH - 1));
`else
    assign clr_done = 1'b1;
`endif

    always_comb begin
        arr_we    = commit && c_we && !c_oor;
        arr_re    = commit && !c_we && !c_oor;
        arr_zero  = commit && !c_we && c_oor;
        arr_idx   = c_idx[IDX_W-1:0];
        arr_wdata = c_wdata;
        arr_be    = c_be;
`ifdef DMEM_INIT_EN
        if (state_q == CLEAR) begin
            arr_we    = 1'b1;
            arr_idx   = clr_q;
            arr_wdata = '0;
            arr_be    = '1;
        end
`endif
        // Nothing reaches the array while reset is held, so an aborted write is dropped.
        if (!reset) arr_we = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RESET_ST;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            oor_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                we_q    <= we;
                idx_q   <= addr[ADDR_W-1:2];
                wdata_q <= write_data;
                be_q    <= byte_en;
            end
            if (commit) oor_q <= c_oor;
        end
    end

    dmem_array #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clk    (clk),
        .rst_n  (reset),
        .we_i   (arr_we),
        .re_i   (arr_re),
        .zero_i (arr_zero),
        .idx_i  (arr_idx),
        .wdata_i(arr_wdata),
        .be_i   (arr_be),
        .rdata_o(read_data)
    );

endmodule

// File: tb/tb_dmem_hs.sv
// Bench for dmem_hs: three instances (LATENCY 0, 2, 4) checked every cycle against a
// transaction-level memory model, plus literal expectations from the directed scenarios.
module tb_dmem_hs;

    localparam int NL    = 3;
    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int DEPTH = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n [NL];
    logic          req   [NL];
    logic          we_i  [NL];
    logic [AW-1:0] addr  [NL];
    logic [DW-1:0] wdata [NL];
    logic [3:0]    be    [NL];
    logic          ready [NL];
    logic          rvalid[NL];
    logic          err   [NL];
    logic [DW-1:0] rdata [NL];

    for (genvar g = 0; g < NL; g++) begin : g_dut
        dmem_hs #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .LATENCY(2*g)) u_dut (
            .clk       (clk),
            .reset     (rst_n[g]),
            .req       (req[g]),
            .we        (we_i[g]),
            .addr      (addr[g]),
            .write_data(wdata[g]),
            .byte_en   (be[g]),
            .ready     (ready[g]),
            .rvalid    (rvalid[g]),
            .read_data (rdata[g]),
            .err       (err[g])
        );
    end

    int errors = 0;
    int checks = 0;

    // Model: word array with per-byte known flags, one pending request, expected outputs.
    logic [31:0] mmem  [NL][DEPTH];
    logic [3:0]  mknown[NL][DEPTH];
    bit          pv[NL], pwe[NL];
    int          pdue[NL];
    logic [31:0] paddr[NL], pdata[NL];
    logic [3:0]  pbe[NL];
    bit          rv_exp[NL], err_exp[NL], rdy_exp[NL], acc_last[NL];
    logic [31:0] rd_exp[NL];
    logic [3:0]  rd_known[NL];
    int          clr_left[NL];
    int          ecnt = 0;
    // Observations used by the literal checks.
    int          acc_edge[NL], resp_edge[NL], nresp[NL], rdy_low_cnt[NL];
    logic [31:0] last_rd[NL];
    logic        last_err[NL];

    function automatic logic [31:0] bmask(input logic [3:0] k);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) m[b*8 +: 8] = {8{k[b]}};
        return m;
    endfunction

    task automatic chk(input string name, input int ln, input logic [31:0] act,
                       input logic [31:0] exp, input logic [31:0] mask);
        checks++;
        if ((act & mask) !== (exp & mask)) begin
            errors++;
            $display("FAIL %s lane%0d (LATENCY=%0d) t=%0t: got %h expected %h",
                     name, ln, 2*ln, $time, act, exp);
        end
    endtask

    task automatic lit(input string name, input int ln, input logic [31:0] act, input logic [31:0] exp);
        chk(name, ln, act, exp, 32'hFFFF_FFFF);
    endtask

    task automatic model_reset(input int ln);
        pv[ln]       = 0;
        rv_exp[ln]   = 0;
        err_exp[ln]  = 0;
        rd_exp[ln]   = '0;
        rd_known[ln] = 4'hF;
`ifdef DMEM_INIT_EN
        clr_left[ln] = DEPTH;
        for (int i = 0; i < DEPTH; i++) begin
            mmem[ln][i]   = '0;
            mknown[ln][i] = 4'hF;
        end
`else
        clr_left[ln] = 0;
`endif
    endtask

    task automatic model_commit(input int ln);
        longint unsigned idx;
        idx = paddr[ln][31:2];
        rv_exp[ln]  = 1;
        err_exp[ln] = (idx >= DEPTH);
        if (idx >= DEPTH) begin
            if (!pwe[ln]) begin
                rd_exp[ln]   = '0;
                rd_known[ln] = 4'hF;
            end
        end else if (pwe[ln]) begin
            for (int b = 0; b < 4; b++) begin
                if (pbe[ln][b]) begin
                    mmem[ln][idx][b*8 +: 8] = pdata[ln][b*8 +: 8];
                    mknown[ln][idx][b]      = 1'b1;
                end
            end
        end else begin
            rd_exp[ln]   = mmem[ln][idx];
            rd_known[ln] = mknown[ln][idx];
        end
    endtask

    initial begin
        for (int ln = 0; ln < NL; ln++) begin
            for (int i = 0; i < DEPTH; i++) begin
                mmem[ln][i]   = '0;
                mknown[ln][i] = '0;
            end
            model_reset(ln);
            rdy_exp[ln] = 0; acc_last[ln] = 0;
            nresp[ln] = 0; rdy_low_cnt[ln] = 0;
            acc_edge[ln] = 0; resp_edge[ln] = 0;
            last_rd[ln] = '0; last_err[ln] = 0;
        end
        forever begin
            @(posedge clk);
            ecnt++;
            for (int ln = 0; ln < NL; ln++) begin
                acc_last[ln] = 0;
                if (rst_n[ln]) begin
                    if (clr_left[ln] > 0) clr_left[ln]--;
                    rv_exp[ln]  = 0;
                    err_exp[ln] = 0;
                    if (req[ln] && rdy_exp[ln]) begin
                        acc_last[ln] = 1;
                        acc_edge[ln] = ecnt;
                        pv[ln]    = 1;
                        pdue[ln]  = ecnt + 2*ln;
                        pwe[ln]   = we_i[ln];
                        paddr[ln] = addr[ln];
                        pdata[ln] = wdata[ln];
                        pbe[ln]   = be[ln];
                    end
                    if (pv[ln] && pdue[ln] == ecnt) begin
                        pv[ln] = 0;
                        model_commit(ln);
                    end
                end
            end
            @(negedge clk);
            for (int ln = 0; ln < NL; ln++) begin
                if (!rst_n[ln]) model_reset(ln);
                rdy_exp[ln] = (clr_left[ln] == 0) && !pv[ln];
                chk("ready", ln, 32'(ready[ln]), 32'(rdy_exp[ln]), 32'h1);
                chk("rvalid", ln, 32'(rvalid[ln]), 32'(rv_exp[ln]), 32'h1);
                chk("err", ln, 32'(err[ln]), 32'(err_exp[ln]), 32'h1);
                if (rv_exp[ln] || !rst_n[ln])
                    chk("read_data", ln, rdata[ln], rd_exp[ln], bmask(rd_known[ln]));
                if (rvalid[ln]) begin
                    nresp[ln]++;
                    last_rd[ln]   = rdata[ln];
                    last_err[ln]  = err[ln];
                    resp_edge[ln] = ecnt;
                end
                if (rst_n[ln] && !ready[ln]) rdy_low_cnt[ln]++;
            end
        end
    end

    task automatic issue(input int ln, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] b);
        int n;
        req[ln] = 1; we_i[ln] = w; addr[ln] = a; wdata[ln] = d; be[ln] = b;
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!acc_last[ln] && n < 200);
        if (!acc_last[ln]) begin
            checks++; errors++;
            $display("FAIL accept_timeout lane%0d: got no accept after %0d cycles, required accept", ln, n);
            req[ln] = 0;
        end
    endtask

    task automatic idle(input int ln, input int n);
        req[ln] = 0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int ln);
        req[ln] = 0;
        rst_n[ln] = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n[ln] = 1;
`ifdef DMEM_INIT_EN
        repeat (DEPTH + 1) @(posedge clk);
        #1;
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    logic [31:0] old8;

    initial begin
        for (int ln = 0; ln < NL; ln++) begin
            rst_n[ln] = 0; req[ln] = 0; we_i[ln] = 0;
            addr[ln] = '0; wdata[ln] = '0; be[ln] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
`ifdef DMEM_INIT_EN
        lit("reset_ready", 1, 32'(ready[1]), 32'h0);
`else
        lit("reset_ready", 1, 32'(ready[1]), 32'h1);
`endif
        lit("reset_rvalid", 1, 32'(rvalid[1]), 32'h0);
        lit("reset_err", 1, 32'(err[1]), 32'h0);
        lit("reset_read_data", 1, rdata[1], 32'h0);

        for (int ln = 0; ln < NL; ln++) rst_n[ln] = 1;
        for (int ln = 0; ln < NL; ln++) rdy_low_cnt[ln] = 0;
`ifdef DMEM_INIT_EN
        repeat (DEPTH + 6) @(posedge clk);
        #1;
        lit("clear_ready_low_cycles", 0, 32'(rdy_low_cnt[0]), 32'(DEPTH));
        issue(0, 0, 32'h0000_00F4, 0, 4'h0);
        idle(0, 3);
        lit("clear_word61_zero", 0, last_rd[0], 32'h0);
`else
        repeat (5) @(posedge clk);
        #1;
        lit("ready_after_release", 0, 32'(rdy_low_cnt[0]), 32'h0);
`endif

        // Write then read back with two wait states.
        issue(1, 1, 32'h10, 32'hDEAD_BEEF, 4'hF);
        idle(1, 5);
        lit("write_resp_latency", 1, 32'(resp_edge[1] - acc_edge[1]), 32'd2);
        issue(1, 0, 32'h10, 32'h0, 4'h0);
        idle(1, 5);
        lit("readback_data", 1, last_rd[1], 32'hDEAD_BEEF);
        lit("readback_err", 1, 32'(last_err[1]), 32'h0);

        // Byte-lane merge.
        issue(1, 1, 32'h20, 32'hAABB_CCDD, 4'hF);
        issue(1, 1, 32'h20, 32'h0000_0011, 4'h1);
        issue(1, 0, 32'h20, 32'h0, 4'h0);
        idle(1, 6);
        lit("byte_lane_merge", 1, last_rd[1], 32'hAABB_CC11);

        // Zero latency back-to-back reads.
        issue(0, 1, 32'h4, 32'h1111_0001, 4'hF);
        issue(0, 1, 32'h8, 32'h2222_0002, 4'hF);
        issue(0, 1, 32'hC, 32'h3333_0003, 4'hF);
        idle(0, 3);
        nresp[0] = 0; rdy_low_cnt[0] = 0;
        issue(0, 0, 32'h4, 32'h0, 4'h0);
        issue(0, 0, 32'h8, 32'h0, 4'h0);
        issue(0, 0, 32'hC, 32'h0, 4'h0);
        idle(0, 3);
        lit("b2b_rvalid_count", 0, 32'(nresp[0]), 32'd3);
        lit("b2b_ready_low", 0, 32'(rdy_low_cnt[0]), 32'd0);
        lit("b2b_last_data", 0, last_rd[0], 32'h3333_0003);

        // Out of range, including an index that would alias if truncated.
        issue(1, 0, 32'h100, 32'h0, 4'h0);
        idle(1, 5);
        lit("oor_read_err", 1, 32'(last_err[1]), 32'h1);
        lit("oor_read_data", 1, last_rd[1], 32'h0);
        issue(1, 1, 32'h100, 32'h5555_5555, 4'hF);
        idle(1, 5);
        lit("oor_write_err", 1, 32'(last_err[1]), 32'h1);
        issue(1, 1, 32'h8000_0010, 32'h6666_6666, 4'hF);
        issue(1, 0, 32'h10, 32'h0, 4'h0);
        idle(1, 5);
        lit("no_alias_write", 1, last_rd[1], 32'hDEAD_BEEF);

        // Reset during the wait of a four-cycle write.
`ifdef DMEM_INIT_EN
        old8 = 32'h0;
`else
        old8 = 32'h0BAD_F00D;
        issue(2, 1, 32'h8, old8, 4'hF);
        idle(2, 7);
`endif
        nresp[2] = 0;
        issue(2, 1, 32'h8, 32'h1234_5678, 4'hF);
        req[2] = 0;
        repeat (2) @(posedge clk);
        #1;
        do_reset(2);
        idle(2, 6);
        lit("abort_no_rvalid", 2, 32'(nresp[2]), 32'd0);
        issue(2, 0, 32'h8, 32'h0, 4'h0);
        idle(2, 7);
        lit("abort_old_value", 2, last_rd[2], old8);

        // Randomized traffic on every instance.
        for (int ln = 0; ln < NL; ln++) begin
            for (int k = 0; k < 150; k++) begin
                logic [31:0] a;
                int sel;
                sel = $urandom_range(0, 9);
                if (sel == 0)      a = $urandom;
                else if (sel == 1) a = 32'(DEPTH*4 + $urandom_range(0, 63));
                else               a = 32'(($urandom_range(0, DEPTH-1) << 2) | $urandom_range(0, 3));
                issue(ln, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom));
                sel = $urandom_range(0, 3);
                if (sel != 0) idle(ln, sel);
                if ($urandom_range(0, 49) == 0) begin
                    req[ln] = 0;
                    repeat ($urandom_range(0, 2*ln)) @(posedge clk);
                    #1;
                    do_reset(ln);
                end
            end
            idle(ln, 2*ln + 3);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
